dot_accumulator: RTL and testbench

- Sits directly downstream of the instruction decoder and the PE array.
- Consumes per-lane multiply results from the PEs, plus the decoder's 2-bit dot-product control, and produces the dot-product value written back to data BRAM when r_select=1.
- Reduces the lanes through a registered adder tree, then applies shift (load), accumulate or clear to a running accumulator.

---
 rtl/dot_accumulator_pkg.sv | 11 +
 rtl/dot_accumulator_adder_tree_pipe.sv | 77 +++++++
 rtl/dot_accumulator.sv | 61 ++++++
 tb/tb_dot_accumulator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dot_accumulator_pkg.sv
// rtl/dot_accumulator_pkg.sv - dot-product control encodings shared with the instruction decoder
package dot_accumulator_pkg;

    typedef logic [1:0] dot_ctrl_t;

    localparam dot_ctrl_t DOT_NONE  = 2'b00;
    localparam dot_ctrl_t DOT_SHIFT = 2'b01;
    localparam dot_ctrl_t DOT_ACC   = 2'b10;
    localparam dot_ctrl_t DOT_CLEAR = 2'b11;

endpackage

// File: rtl/dot_accumulator_adder_tree_pipe.sv
// rtl/dot_accumulator_adder_tree_pipe.sv - registered lane reduction with valid/ctrl sideband
module adder_tree_pipe
    import dot_accumulator_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  dot_ctrl_t                   in_ctrl,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    output logic                        out_valid,
    output dot_ctrl_t                   out_ctrl,
    output logic [DATA_WIDTH-1:0]       out_sum,
    output logic                        busy
);

    localparam int TREE_DEPTH = $clog2(LANES);

    // Registered nodes stored level by level; the root is the last entry.
    logic [DATA_WIDTH-1:0] node [LANES-1];
    logic                  vld  [TREE_DEPTH];
    dot_ctrl_t             ctl  [TREE_DEPTH];

    for (genvar l = 1; l <= TREE_DEPTH; l++) begin : g_lvl
        localparam int N   = LANES >> l;
        localparam int OFF = LANES - (LANES >> (l - 1));
        for (genvar i = 0; i < N; i++) begin : g_node
            logic [DATA_WIDTH-1:0] a;
            logic [DATA_WIDTH-1:0] b;
            if (l == 1) begin : g_leaf
                assign a = in_data[(2*i)*DATA_WIDTH +: DATA_WIDTH];
                assign b = in_data[(2*i+1)*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_inner
                localparam int POFF = LANES - (LANES >> (l - 2));
                assign a = node[POFF + 2*i];
                assign b = node[POFF + 2*i + 1];
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    node[OFF + i] <= '0;
                end else begin
                    node[OFF + i] <= a + b;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TREE_DEPTH; i++) begin
                vld[i] <= 1'b0;
                ctl[i] <= DOT_NONE;
            end
        end else begin
            vld[0] <= in_valid;
            ctl[0] <= in_ctrl;
            for (int i = 1; i < TREE_DEPTH; i++) begin
                vld[i] <= vld[i-1];
                ctl[i] <= ctl[i-1];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < TREE_DEPTH; i++) begin
            busy = busy | vld[i];
        end
    end

    assign out_valid = vld[TREE_DEPTH-1];
    assign out_ctrl  = ctl[TREE_DEPTH-1];
    assign out_sum   = node[LANES-2];

endmodule

// File: rtl/dot_accumulator.sv
// rtl/dot_accumulator.sv - pipelined lane reduction feeding a shift/accumulate/clear accumulator
module dot_accumulator
    import dot_accumulator_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [1:0]                  dot_ctrl,
    input  logic [LANES*DATA_WIDTH-1:0] pe_out,
    output logic [DATA_WIDTH-1:0]       dot_out,
    output logic                        dot_valid,
    output logic                        busy
);

    logic                  accept;
    logic                  t_valid;
    dot_ctrl_t             t_ctrl;
    logic [DATA_WIDTH-1:0] t_sum;
    logic [DATA_WIDTH-1:0] acc;

    // DOT_NONE is a bubble: it never enters the sideband, so busy ignores it.
    assign accept = in_valid && (dot_ctrl != DOT_NONE);

    adder_tree_pipe #(
        .LANES      (LANES),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_ctrl   (dot_ctrl),
        .in_data   (pe_out),
        .out_valid (t_valid),
        .out_ctrl  (t_ctrl),
        .out_sum   (t_sum),
        .busy      (busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            dot_valid <= 1'b0;
        end else begin
            dot_valid <= t_valid && ((t_ctrl == DOT_SHIFT) || (t_ctrl == DOT_ACC));
            if (t_valid) begin
                case (t_ctrl)
                    DOT_SHIFT: acc <= t_sum;
                    DOT_ACC:   acc <= acc + t_sum;
                    DOT_CLEAR: acc <= '0;
                    default:   acc <= acc;
                endcase
            end
        end
    end

    assign dot_out = acc;

endmodule

// File: tb/tb_dot_accumulator.sv
// tb/tb_dot_accumulator.sv - scoreboard bench for dot_accumulator with directed vectors
module tb_dot_accumulator;

    localparam int LANES = 4;
    localparam int DW    = 32;
    localparam int LAT   = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [1:0]        dot_ctrl = 2'b00;
    logic [LANES*DW-1:0] pe_out = '0;
    logic [DW-1:0]     dot_out;
    logic              dot_valid;
    logic              busy;

    dot_accumulator #(.LANES(LANES), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .dot_ctrl  (dot_ctrl),
        .pe_out    (pe_out),
        .dot_out   (dot_out),
        .dot_valid (dot_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] val;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;
    logic [DW-1:0] model_acc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every dot_valid pulse must match the oldest expected retirement.
    always @(negedge clk) begin
        if (dot_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_dot_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dot_out_on_valid", dot_out, e.val);
                check("retire_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic v, input logic [1:0] c,
                         input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                         input logic [DW-1:0] l2, input logic [DW-1:0] l3,
                         input bit expect_ret);
        logic [DW-1:0] s;
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v;
        dot_ctrl = c;
        pe_out   = {l3, l2, l1, l0};
        s = l0 + l1 + l2 + l3;
        if (v && c != 2'b00) begin
            case (c)
                2'b01: model_acc = s;
                2'b10: model_acc = model_acc + s;
                default: model_acc = '0;
            endcase
            if (expect_ret && c != 2'b11) begin
                e.val = model_acc;
                e.cyc = cyc + LAT;
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dot_ctrl = 2'b00;
        pe_out   = '0;
    endtask

    task automatic wait_cyc(input int target);
        int guard;
        guard = 0;
        @(negedge clk);
        while (cyc < target && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) check("wait_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int c0;
        #2;
        check("reset_dot_out", dot_out, 32'd0);
        check("reset_dot_valid", {31'd0, dot_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Shift {1,2,3,4}
        issue(1'b1, 2'b01, 32'd1, 32'd2, 32'd3, 32'd4, 1'b1);
        c0 = cyc;
        idle();
        wait_cyc(c0 + 1);
        check("busy_in_flight", {31'd0, busy}, 32'd1);
        wait_cyc(c0 + 3);
        check("busy_drained", {31'd0, busy}, 32'd0);
        wait_cyc(c0 + 4);
        check("shift_valid_pulse_ends", {31'd0, dot_valid}, 32'd0);
        check("shift_hold", dot_out, 32'd10);

        // Shift then back-to-back accumulate
        issue(1'b1, 2'b01, 32'd1, 32'd1, 32'd1, 32'd1, 1'b1);
        issue(1'b1, 2'b10, 32'd2, 32'd2, 32'd2, 32'd2, 1'b1);
        c0 = cyc;
        idle();
        wait_cyc(c0 + 5);
        check("acc_hold", dot_out, 32'd12);

        // Clear behind accumulate
        issue(1'b1, 2'b10, 32'd1, 32'd1, 32'd1, 32'd1, 1'b1);
        c0 = cyc;
        issue(1'b1, 2'b11, 32'd7, 32'd7, 32'd7, 32'd7, 1'b1);
        idle();
        wait_cyc(c0 + 4);
        check("clear_dot_out", dot_out, 32'd0);
        check("clear_no_valid", {31'd0, dot_valid}, 32'd0);
        wait_cyc(c0 + 6);
        check("clear_hold", dot_out, 32'd0);

        // Wrap-around
        issue(1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(1'b1, 2'b10, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd2, 1'b1);
        issue(1'b1, 2'b10, 32'd1, 32'd0, 32'd0, 32'd0, 1'b1);
        c0 = cyc;
        idle();
        wait_cyc(c0 + 5);
        check("wrap_final", dot_out, 32'd0);

        // Gating: in_valid low, and dot_ctrl none
        issue(1'b1, 2'b01, 32'd7, 32'd0, 32'd0, 32'd0, 1'b1);
        issue(1'b0, 2'b01, 32'd9, 32'd9, 32'd9, 32'd9, 1'b1);
        c0 = cyc;
        issue(1'b1, 2'b00, 32'd9, 32'd9, 32'd9, 32'd9, 1'b1);
        idle();
        wait_cyc(c0 + 2);
        check("gated_busy", {31'd0, busy}, 32'd0);
        wait_cyc(c0 + 6);
        check("gated_dot_out", dot_out, 32'd7);

        // Reset in the middle of a shift
        issue(1'b1, 2'b01, 32'd5, 32'd5, 32'd5, 32'd5, 1'b0);
        idle();
        #1 rst = 1'b1;
        #2;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_dot_out", dot_out, 32'd0);
        check("midrst_dot_valid", {31'd0, dot_valid}, 32'd0);
        rst = 1'b0;
        model_acc = '0;
        c0 = cyc;
        wait_cyc(c0 + 6);
        check("post_rst_dot_out", dot_out, 32'd0);

        // Recovery after reset
        issue(1'b1, 2'b10, 32'd4, 32'd3, 32'd2, 32'd1, 1'b1);
        c0 = cyc;
        idle();
        wait_cyc(c0 + 5);
        check("recover_dot_out", dot_out, 32'd10);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
